peripheral_bus_controller: RTL and testbench

//  Initiator side of the peripheral bus: bridges a Wishbone classic slave port to the

---
 rtl/peripheral_bus_controller.sv | 138 +++++++++++++
 tb/tb_peripheral_bus_controller.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/peripheral_bus_controller.sv
// rtl/peripheral_bus_controller.sv - Wishbone classic slave to shared peripheral bus bridge
//
// Purpose: accepts one Wishbone access at a time when wb_adr_i[23:16] selects the
// peripheral bus, runs it on the shared device bus (stretched by device busy), and
// returns a one-cycle ack or error together with the read data.
//
// Ports:
//   clk, rst                   clock, synchronous active-high reset
//   wb_cyc_i, wb_stb_i         Wishbone cycle / strobe
//   wb_we_i, wb_sel_i          Wishbone write enable / byte select
//   wb_adr_i, wb_data_i        Wishbone byte address / write data
//   wb_ack_o, wb_error_o       one-cycle completion pulses (ok / failed)
//   wb_data_o                  read data, valid with ack/error, held until next response
//   peripheralEnable           high for the whole device access
//   peripheralBus_we/_oe       write / read strobes, exactly one high while enabled
//   peripheralBus_busy         OR of device busy, stretches the access
//   peripheralBus_address      device byte address
//   peripheralBus_byteSelect   byte lanes
//   peripheralBus_dataWrite    write data
//   peripheralBus_dataRead     muxed device read data
//   requestOutput              some device is driving peripheralBus_dataRead
module peripheral_bus_controller #(
  parameter logic [7:0] ADDRESS_MATCH     = 8'h13,
  parameter int         TIMEOUT_CYCLES    = 256,
  parameter bit         ERROR_ON_UNMAPPED = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wb_cyc_i,
  input  logic        wb_stb_i,
  input  logic        wb_we_i,
  input  logic [3:0]  wb_sel_i,
  input  logic [23:0] wb_adr_i,
  input  logic [31:0] wb_data_i,
  output logic        wb_ack_o,
  output logic        wb_error_o,
  output logic [31:0] wb_data_o,
  output logic        peripheralEnable,
  output logic        peripheralBus_we,
  output logic        peripheralBus_oe,
  input  logic        peripheralBus_busy,
  output logic [15:0] peripheralBus_address,
  output logic [3:0]  peripheralBus_byteSelect,
  output logic [31:0] peripheralBus_dataWrite,
  input  logic [31:0] peripheralBus_dataRead,
  input  logic        requestOutput
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] ACCESS  = 2'd1;
  localparam logic [1:0] RESPOND = 2'd2;

  localparam int            COUNT_W    = $clog2(TIMEOUT_CYCLES);
  localparam logic [COUNT_W-1:0] COUNT_LAST = COUNT_W'(TIMEOUT_CYCLES - 1);

  logic [1:0]         state;
  logic [COUNT_W-1:0] busyCount;
  logic               hit;

  assign hit = wb_cyc_i & wb_stb_i & (wb_adr_i[23:16] == ADDRESS_MATCH);

  // All bus-facing strobes are flops so they cannot glitch; we/oe are forced low
  // outside ACCESS, so peripheralBus_we doubles as the latched direction while active.
  always_ff @(posedge clk) begin
    if (rst) begin
      state                    <= IDLE;
      busyCount                <= '0;
      peripheralEnable         <= 1'b0;
      peripheralBus_we         <= 1'b0;
      peripheralBus_oe         <= 1'b0;
      peripheralBus_address    <= '0;
      peripheralBus_byteSelect <= '0;
      peripheralBus_dataWrite  <= '0;
      wb_ack_o                 <= 1'b0;
      wb_error_o               <= 1'b0;
      wb_data_o                <= 32'hFFFF_FFFF;
    end else begin
      wb_ack_o   <= 1'b0;
      wb_error_o <= 1'b0;
      case (state)
        IDLE: begin
          if (hit) begin
            state                    <= ACCESS;
            peripheralEnable         <= 1'b1;
            peripheralBus_we         <= wb_we_i;
            peripheralBus_oe         <= ~wb_we_i;
            peripheralBus_address    <= wb_adr_i[15:0];
            peripheralBus_byteSelect <= wb_sel_i;
            peripheralBus_dataWrite  <= wb_data_i;
          end
        end
        ACCESS: begin
          if (!wb_cyc_i) begin
            // Master abort wins over completion: drop the access silently.
            state            <= IDLE;
            busyCount        <= '0;
            peripheralEnable <= 1'b0;
            peripheralBus_we <= 1'b0;
            peripheralBus_oe <= 1'b0;
          end else if (!peripheralBus_busy) begin
            state            <= RESPOND;
            peripheralEnable <= 1'b0;
            peripheralBus_we <= 1'b0;
            peripheralBus_oe <= 1'b0;
            if (peripheralBus_we) begin
              wb_ack_o <= 1'b1;
            end else if (requestOutput) begin
              wb_ack_o  <= 1'b1;
              wb_data_o <= peripheralBus_dataRead;
            end else begin
              // Nobody decoded the read address: return all-ones.
              wb_ack_o   <= ~ERROR_ON_UNMAPPED;
              wb_error_o <= ERROR_ON_UNMAPPED;
              wb_data_o  <= 32'hFFFF_FFFF;
            end
          end else if (busyCount == COUNT_LAST) begin
            state            <= RESPOND;
            peripheralEnable <= 1'b0;
            peripheralBus_we <= 1'b0;
            peripheralBus_oe <= 1'b0;
            wb_error_o       <= 1'b1;
            wb_data_o        <= 32'hFFFF_FFFF;
          end else begin
            busyCount <= busyCount + 1'b1;
          end
        end
        RESPOND: begin
          state     <= IDLE;
          busyCount <= '0;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_peripheral_bus_controller.sv
// tb/tb_peripheral_bus_controller.sv - randomized self-checking bench for peripheral_bus_controller
module tb_peripheral_bus_controller;

  localparam int TO = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        wb_cyc_i, wb_stb_i, wb_we_i;
  logic [3:0]  wb_sel_i;
  logic [23:0] wb_adr_i;
  logic [31:0] wb_data_i;
  logic        wb_ack_o, wb_error_o;
  logic [31:0] wb_data_o;
  logic        peripheralEnable, peripheralBus_we, peripheralBus_oe, peripheralBus_busy;
  logic [15:0] peripheralBus_address;
  logic [3:0]  peripheralBus_byteSelect;
  logic [31:0] peripheralBus_dataWrite, peripheralBus_dataRead;
  logic        requestOutput;

  peripheral_bus_controller #(
    .ADDRESS_MATCH(8'h13), .TIMEOUT_CYCLES(TO), .ERROR_ON_UNMAPPED(1'b1)
  ) dut (
    .clk(clk), .rst(rst),
    .wb_cyc_i(wb_cyc_i), .wb_stb_i(wb_stb_i), .wb_we_i(wb_we_i), .wb_sel_i(wb_sel_i),
    .wb_adr_i(wb_adr_i), .wb_data_i(wb_data_i),
    .wb_ack_o(wb_ack_o), .wb_error_o(wb_error_o), .wb_data_o(wb_data_o),
    .peripheralEnable(peripheralEnable), .peripheralBus_we(peripheralBus_we),
    .peripheralBus_oe(peripheralBus_oe), .peripheralBus_busy(peripheralBus_busy),
    .peripheralBus_address(peripheralBus_address),
    .peripheralBus_byteSelect(peripheralBus_byteSelect),
    .peripheralBus_dataWrite(peripheralBus_dataWrite),
    .peripheralBus_dataRead(peripheralBus_dataRead),
    .requestOutput(requestOutput)
  );

  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;

  // Per-cycle expectations, written by the stimulus process from the transaction model.
  logic        eChk = 1'b0;
  logic        eEn, eWe, eOe, eAck, eErr, eBus;
  logic [15:0] eAddr;
  logic [3:0]  eSel;
  logic [31:0] eDw;
  logic        eDataKnown = 1'b0;
  logic [31:0] eData;

  // Observations used by the literal checks.
  int          cycIdx, enCount, respCycle;
  logic [15:0] lastAddr;
  logic [31:0] lastDw, lastRdata;
  logic        lastAck, lastErr, lastWe;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h (time %0t)", name, act, exp, $time);
  endtask

  always @(negedge clk) begin
    if (eChk) begin
      check("enable", 32'(peripheralEnable), 32'(eEn));
      check("we", 32'(peripheralBus_we), 32'(eWe));
      check("oe", 32'(peripheralBus_oe), 32'(eOe));
      check("ack", 32'(wb_ack_o), 32'(eAck));
      check("error", 32'(wb_error_o), 32'(eErr));
      if (eBus) begin
        check("address", 32'(peripheralBus_address), 32'(eAddr));
        check("byteSelect", 32'(peripheralBus_byteSelect), 32'(eSel));
        check("dataWrite", peripheralBus_dataWrite, eDw);
      end
      if (eDataKnown) check("wb_data_o", wb_data_o, eData);
      if (peripheralEnable) begin
        enCount++;
        lastAddr = peripheralBus_address;
        lastDw   = peripheralBus_dataWrite;
        lastWe   = peripheralBus_we;
      end
      if (wb_ack_o || wb_error_o) begin
        respCycle = cycIdx;
        lastAck   = wb_ack_o;
        lastErr   = wb_error_o;
        lastRdata = wb_data_o;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic setIdle();
    eEn = 0; eWe = 0; eOe = 0; eAck = 0; eErr = 0; eBus = 0;
  endtask

  task automatic dropMaster();
    wb_cyc_i = 0; wb_stb_i = 0; peripheralBus_busy = 0;
  endtask

  // One Wishbone transaction. busyN = number of leading busy cycles seen by the access;
  // abortAt/rstAt = ACCESS cycle (1-based) in which cyc drops / rst pulses, 0 = never.
  task automatic runTxn(input logic we, input logic [23:0] adr, input logic [3:0] sel,
                        input logic [31:0] d, input int busyN, input logic req,
                        input logic [31:0] rd, input int abortAt, input int rstAt);
    bit          mapped  = (adr[23:16] == 8'h13);
    bit          timeOut = (busyN >= TO);
    int          accLen  = timeOut ? TO : busyN + 1;
    bit          respErr = timeOut || (!we && !req);
    logic [31:0] respData = (timeOut || !req) ? 32'hFFFF_FFFF : rd;
    enCount = 0; respCycle = -1; lastAck = 0; lastErr = 0;
    step();
    cycIdx = 0;
    wb_cyc_i = 1; wb_stb_i = 1; wb_we_i = we; wb_sel_i = sel; wb_adr_i = adr; wb_data_i = d;
    peripheralBus_busy = 0; requestOutput = req; peripheralBus_dataRead = rd;
    setIdle();
    if (!mapped) begin
      for (int k = 1; k <= 3; k++) begin
        step(); cycIdx = k; setIdle();
      end
      step(); cycIdx = 4; dropMaster(); setIdle();
      return;
    end
    for (int k = 1; k <= accLen; k++) begin
      step();
      cycIdx = k;
      peripheralBus_busy = (k <= busyN);
      eEn = 1; eWe = we; eOe = ~we; eAck = 0; eErr = 0;
      eBus = 1; eAddr = adr[15:0]; eSel = sel; eDw = d;
      if (k == abortAt) begin wb_cyc_i = 0; wb_stb_i = 0; end
      if (k == rstAt) rst = 1;
      if (k == abortAt || k == rstAt) begin
        step();
        cycIdx = k + 1;
        if (k == rstAt) begin eDataKnown = 1; eData = 32'hFFFF_FFFF; end
        rst = 0; dropMaster(); setIdle();
        return;
      end
    end
    step();
    cycIdx = accLen + 1;
    peripheralBus_busy = 0;
    setIdle();
    eAck = ~respErr; eErr = respErr;
    if (!we || timeOut) begin eDataKnown = 1; eData = respData; end
    else eDataKnown = 0;
    step();
    cycIdx = accLen + 2;
    dropMaster(); setIdle();
  endtask

  initial begin
    rst = 1; dropMaster(); wb_we_i = 0; wb_sel_i = 0; wb_adr_i = 0; wb_data_i = 0;
    requestOutput = 0; peripheralBus_dataRead = 0;
    setIdle();
    step(); step();
    @(negedge clk);
    check("rst enable", 32'(peripheralEnable), 32'd0);
    check("rst we/oe", 32'({peripheralBus_we, peripheralBus_oe}), 32'd0);
    check("rst ack/err", 32'({wb_ack_o, wb_error_o}), 32'd0);
    check("rst wb_data_o", wb_data_o, 32'hFFFF_FFFF);
    check("rst address", 32'(peripheralBus_address), 32'd0);
    check("rst bus", peripheralBus_dataWrite | 32'(peripheralBus_byteSelect), 32'd0);
    rst = 0;
    eDataKnown = 1; eData = 32'hFFFF_FFFF;
    eChk = 1;

    // Directed scenarios with hand-computed expectations.
    runTxn(1, 24'h130004, 4'hF, 32'hA5A5_1234, 0, 0, 0, 0, 0);
    check("t1 enable cycles", enCount, 1);
    check("t1 ack cycle", respCycle, 2);
    check("t1 address", 32'(lastAddr), 32'h0000_0004);
    check("t1 dataWrite", lastDw, 32'hA5A5_1234);
    check("t1 we", 32'(lastWe), 32'd1);
    check("t1 ack/err", 32'({lastAck, lastErr}), 32'b10);

    runTxn(0, 24'h130020, 4'hF, 32'h0, 0, 1, 32'h0000_00FF, 0, 0);
    check("t2 enable cycles", enCount, 1);
    check("t2 ack/err", 32'({lastAck, lastErr}), 32'b10);
    check("t2 rdata", lastRdata, 32'h0000_00FF);

    runTxn(0, 24'h130100, 4'hF, 32'h0, 0, 0, 32'h1234_5678, 0, 0);
    check("t3 ack/err", 32'({lastAck, lastErr}), 32'b01);
    check("t3 rdata", lastRdata, 32'hFFFF_FFFF);

    runTxn(1, 24'h130008, 4'h3, 32'h0BAD_F00D, 5, 0, 0, 0, 0);
    check("t4 enable cycles", enCount, 6);
    check("t4 ack cycle", respCycle, 7);

    runTxn(0, 24'h13000C, 4'hF, 32'h0, 40, 1, 32'h5555_AAAA, 0, 0);
    check("t5 enable cycles", enCount, 8);
    check("t5 error cycle", respCycle, 9);
    check("t5 ack/err", 32'({lastAck, lastErr}), 32'b01);
    check("t5 rdata", lastRdata, 32'hFFFF_FFFF);

    runTxn(1, 24'h140000, 4'hF, 32'h1, 0, 0, 0, 0, 0);
    check("t6 unmapped enable", enCount, 0);
    check("t6 unmapped response", respCycle, -1);

    runTxn(1, 24'h130010, 4'hF, 32'h2, 5, 0, 0, 3, 0);
    check("t6 abort enable", enCount, 3);
    check("t6 abort response", respCycle, -1);

    runTxn(0, 24'h130014, 4'hF, 32'h3, 5, 1, 32'h7, 0, 2);
    check("t6 rst enable", enCount, 2);
    check("t6 rst response", respCycle, -1);

    // Randomized traffic against the transaction model.
    for (int n = 0; n < 150; n++) begin
      logic [23:0] adr;
      int          busyN, accLen, abortAt, rstAt;
      adr[15:0]  = 16'($urandom);
      adr[23:16] = ($urandom_range(0, 7) == 0) ? (8'h13 ^ 8'($urandom_range(1, 255))) : 8'h13;
      busyN   = $urandom_range(0, 10);
      accLen  = (busyN >= TO) ? TO : busyN + 1;
      abortAt = 0;
      rstAt   = 0;
      if ($urandom_range(0, 9) == 0) abortAt = $urandom_range(1, accLen);
      else if ($urandom_range(0, 14) == 0) rstAt = $urandom_range(1, accLen);
      runTxn(1'($urandom), adr, 4'($urandom), $urandom, busyN, 1'($urandom), $urandom,
             abortAt, rstAt);
      for (int g = 0; g < $urandom_range(0, 2); g++) begin
        step(); setIdle();
      end
    end

    step();
    eChk = 0;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
